// File: rtl/ro_sched_mux_if.sv
// Bus between the readout scheduler and its channel array / consumer:
// enable and mode controls, per-channel polarity inputs, and the registered report.
interface ro_sched_mux_if #(
  parameter int N_CH  = 16,
  parameter int IDX_W = $clog2(N_CH)
);
  logic             en;
  logic             mode;
  logic [N_CH-1:0]  in_pol;
  logic [N_CH-1:0]  in_pol_eve;
  logic             out_pol;
  logic             out_pol_eve;
  logic [IDX_W-1:0] out_ch;
  logic             out_valid;
  logic [N_CH-1:0]  gray_count;

  modport master (
    output en, mode, in_pol, in_pol_eve,
    input  out_pol, out_pol_eve, out_ch, out_valid, gray_count
  );

  modport slave (
    input  en, mode, in_pol, in_pol_eve,
    output out_pol, out_pol_eve, out_ch, out_valid, gray_count
  );
endinterface

// File: rtl/ro_sched_mux.sv
// Time-multiplexed readout scheduler: one channel per enabled cycle, chosen round-robin
// or binary-weighted, with sticky capture so short pulses wait for the channel's next read.
module ro_sched_mux #(
  parameter int N_CH  = 16,
  parameter int IDX_W = $clog2(N_CH)
) (
  input logic             clk_ext,
  input logic             reset,
  ro_sched_mux_if.slave   bus
);

  logic [N_CH-1:0]  cnt_reg;
  logic [N_CH-1:0]  cnt_inc;
  logic [N_CH-1:0]  cnt_next;
  logic [IDX_W-1:0] rr_reg;
  logic [IDX_W-1:0] rr_next;
  logic [IDX_W-1:0] tz_sel;
  logic [IDX_W-1:0] sel;
  logic [N_CH-1:0]  stk_pol_reg;
  logic [N_CH-1:0]  stk_eve_reg;
  logic [N_CH-1:0]  hit;

  // Weighted pick: lowest set bit of cnt+1, i.e. the gray bit that toggles; wrap maps to top channel.
  always_comb begin
    cnt_inc = cnt_reg + N_CH'(1);
    tz_sel  = IDX_W'(N_CH - 1);
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (cnt_inc[k]) tz_sel = IDX_W'(k);
    end
    sel      = bus.mode ? tz_sel : rr_reg;
    cnt_next = bus.en ? cnt_inc : cnt_reg;
    rr_next  = rr_reg;
    if (bus.en) begin
      rr_next = (rr_reg == IDX_W'(N_CH - 1)) ? '0 : rr_reg + IDX_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_hit
      assign hit[gi] = bus.en && (sel == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk_ext) begin
    if (reset) begin
      cnt_reg        <= '0;
      rr_reg         <= '0;
      stk_pol_reg    <= '0;
      stk_eve_reg    <= '0;
      bus.out_pol    <= 1'b0;
      bus.out_pol_eve <= 1'b0;
      bus.out_ch     <= '0;
      bus.out_valid  <= 1'b0;
      bus.gray_count <= '0;
    end else begin
      cnt_reg        <= cnt_next;
      rr_reg         <= rr_next;
      bus.gray_count <= cnt_next ^ (cnt_next >> 1);
      // The serviced channel's current input goes straight into the report, so it is not re-latched.
      stk_pol_reg    <= (stk_pol_reg | bus.in_pol) & ~hit;
      stk_eve_reg    <= (stk_eve_reg | bus.in_pol_eve) & ~hit;
      bus.out_valid  <= bus.en;
      if (bus.en) begin
        bus.out_pol     <= stk_pol_reg[sel] | bus.in_pol[sel];
        bus.out_pol_eve <= stk_eve_reg[sel] | bus.in_pol_eve[sel];
        bus.out_ch      <= sel;
      end
    end
  end

endmodule

// File: tb/tb_ro_sched_mux.sv
// Directed bench for ro_sched_mux at N_CH=4: reset, both schedules, sticky capture, gating.
module tb_ro_sched_mux;
  localparam int N_CH  = 4;
  localparam int IDX_W = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  ro_sched_mux_if #(.N_CH(N_CH), .IDX_W(IDX_W)) bus ();

  ro_sched_mux #(.N_CH(N_CH), .IDX_W(IDX_W)) dut (
    .clk_ext (clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it, inputs changed for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_pol = '0;
    bus.in_pol_eve = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  int rr_exp [6]  = '{0, 1, 2, 3, 0, 1};
  int wt_exp [16] = '{0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0, 3};
  int gr_exp [16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

  initial begin
    reset = 1'b1;
    bus.en = 1'b1;
    bus.mode = 1'b0;
    bus.in_pol = '1;
    bus.in_pol_eve = '1;
    #1;

    // Reset held with all inputs high and enable asserted
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_valid", bus.out_valid, 0);
      check("rst_pol", bus.out_pol, 0);
      check("rst_eve", bus.out_pol_eve, 0);
      check("rst_ch", bus.out_ch, 0);
      check("rst_gray", bus.gray_count, 0);
    end
    reset = 1'b0;
    step();
    $display("reset release read: ch=%0d pol=%0b", bus.out_ch, bus.out_pol);
    check("post_rst_ch", bus.out_ch, 0);
    check("post_rst_pol", bus.out_pol, 1);
    check("post_rst_valid", bus.out_valid, 1);
    bus.in_pol = '0;
    bus.in_pol_eve = '0;

    // Round-robin sequence
    do_reset();
    bus.mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      $display("rr read %0d: ch=%0d valid=%0b", i, bus.out_ch, bus.out_valid);
      check("rr_ch", bus.out_ch, rr_exp[i]);
      check("rr_valid", bus.out_valid, 1);
      check("rr_pol", bus.out_pol, 0);
    end

    // Sticky pulse on in_pol[3] during channel 1's read
    do_reset();
    step();                       // ch0
    bus.in_pol[3] = 1'b1;
    step();                       // ch1
    bus.in_pol[3] = 1'b0;
    check("stk_ch1_pol", bus.out_pol, 0);
    step();                       // ch2
    check("stk_ch2_pol", bus.out_pol, 0);
    step();                       // ch3
    $display("sticky read: ch=%0d pol=%0b", bus.out_ch, bus.out_pol);
    check("stk_ch3", bus.out_ch, 3);
    check("stk_ch3_pol", bus.out_pol, 1);
    step(); step(); step(); step(); // ch0..ch3
    check("stk_ch3_again", bus.out_ch, 3);
    check("stk_ch3_pol_again", bus.out_pol, 0);

    // Coincident pulse on in_pol_eve[2] in channel 2's read cycle
    step(); step();               // ch0, ch1
    bus.in_pol_eve[2] = 1'b1;
    step();                       // ch2
    bus.in_pol_eve[2] = 1'b0;
    $display("coincident read: ch=%0d eve=%0b", bus.out_ch, bus.out_pol_eve);
    check("coin_ch", bus.out_ch, 2);
    check("coin_eve", bus.out_pol_eve, 1);
    step();                       // ch3
    check("coin_ch3_eve", bus.out_pol_eve, 0);
    step(); step(); step();       // ch0, ch1, ch2
    check("coin_ch_again", bus.out_ch, 2);
    check("coin_eve_again", bus.out_pol_eve, 0);

    // Weighted schedule over one full counter period
    do_reset();
    bus.mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      $display("wt read %0d: ch=%0d gray=%0h", i, bus.out_ch, bus.gray_count);
      check("wt_ch", bus.out_ch, wt_exp[i]);
      check("wt_gray", bus.gray_count, gr_exp[i]);
    end

    // Enable gap with a pulse, then mode switch at cnt=5
    do_reset();
    bus.mode = 1'b0;
    for (int i = 0; i < 4; i++) step(); // ch0..ch3, cnt=4
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_pol[0] = (i == 1);
      step();
      $display("gap cycle %0d: valid=%0b ch=%0d", i, bus.out_valid, bus.out_ch);
      check("gap_valid", bus.out_valid, 0);
      check("gap_ch", bus.out_ch, 3);
      check("gap_gray", bus.gray_count, 6);
    end
    bus.in_pol[0] = 1'b0;
    bus.en = 1'b1;
    step();                       // ch0, cnt becomes 5
    check("resume_ch", bus.out_ch, 0);
    check("resume_pol", bus.out_pol, 1);
    check("resume_valid", bus.out_valid, 1);
    bus.mode = 1'b1;
    step();                       // tz(6)=1
    $display("mode switch read: ch=%0d", bus.out_ch);
    check("switch_ch", bus.out_ch, 1);
    check("switch_gray", bus.gray_count, 5);
    step();                       // tz(7)=0
    check("switch_ch_next", bus.out_ch, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
